// File: rtl/led_cube_scan_driver.sv
// Scan engine for an N x N x N LED cube: N row latches share one data bus,
// N layer drivers select which layer is lit. A double-buffered frame store
// lets the command side fill the back buffer while the front one is scanned.
//
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   enable          - run the scan; sampled in IDLE and at the end of SHOW
//   wr_en/wr_layer/wr_row/wr_data - write one row word into the back buffer
//   swap_req        - exchange front/back at the next frame boundary
//   layers          - one-hot layer enable
//   latches         - one-hot latch clock
//   data            - shared row data bus
//   frame_done      - 1-cycle pulse when the last layer finishes
//   swap_ack        - 1-cycle pulse when a buffer swap commits

module led_cube_scan_driver #(
    parameter int N         = 8,
    parameter int STROBE_W  = 2,
    parameter int ON_CYCLES = 1000,
    parameter int IDX_W     = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_layer,
    input  logic [IDX_W-1:0] wr_row,
    input  logic [N-1:0]     wr_data,
    input  logic             swap_req,
    output logic [N-1:0]     layers,
    output logic [N-1:0]     latches,
    output logic [N-1:0]     data,
    output logic             frame_done,
    output logic             swap_ack
);

    // One counter serves both the strobe phases and the on-time.
    localparam int MAXC  = (ON_CYCLES > STROBE_W) ? ON_CYCLES : STROBE_W;
    localparam int CNT_W = $clog2(MAXC + 1);

    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_W - 1);
    localparam logic [CNT_W-1:0] ON_LAST     = CNT_W'(ON_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        LOAD,
        SHOW
    } state_t;

    typedef enum logic [1:0] {
        SETUP,
        PULSE,
        HOLD
    } phase_t;

    state_t           state;
    phase_t           phase;
    logic [IDX_W-1:0] layer;
    logic [IDX_W-1:0] row;
    logic [CNT_W-1:0] cnt;
    logic             pending;
    logic             fsel;

    // buf_mem[fsel] is the front buffer, buf_mem[~fsel] the back buffer.
    logic [N-1:0] buf_mem [2][N][N];

    logic wr_ok;

    assign wr_ok = wr_en
                && (32'(wr_layer) < N)
                && (32'(wr_row) < N);

    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] i);
        return N'(1) << i;
    endfunction

    // Writes use the pre-edge fsel, so a write on the commit cycle lands
    // in the buffer that becomes the new front.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int l = 0; l < N; l++) begin
                    for (int r = 0; r < N; r++) begin
                        buf_mem[b][l][r] <= '0;
                    end
                end
            end
        end else if (wr_ok) begin
            buf_mem[~fsel][wr_layer][wr_row] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= SETUP;
            layer      <= '0;
            row        <= '0;
            cnt        <= '0;
            pending    <= 1'b0;
            fsel       <= 1'b0;
            layers     <= '0;
            latches    <= '0;
            data       <= '0;
            frame_done <= 1'b0;
            swap_ack   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            swap_ack   <= 1'b0;

            if (swap_req) begin
                pending <= 1'b1;
            end

            // Outputs decode the current state, so they trail it by a cycle.
            layers  <= (state == SHOW) ? onehot(layer) : '0;
            latches <= (state == LOAD && phase == PULSE) ? onehot(row) : '0;
            data    <= (state == LOAD) ? buf_mem[fsel][layer][row] : '0;

            unique case (state)
                IDLE: begin
                    // A request arriving on the commit cycle merges into it.
                    if (pending) begin
                        fsel     <= ~fsel;
                        pending  <= 1'b0;
                        swap_ack <= 1'b1;
                    end
                    if (enable) begin
                        state <= BLANK;
                    end
                end

                BLANK: begin
                    state <= LOAD;
                    row   <= '0;
                    phase <= SETUP;
                    cnt   <= '0;
                end

                LOAD: begin
                    if (cnt != STROBE_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        unique case (phase)
                            SETUP: phase <= PULSE;
                            PULSE: phase <= HOLD;
                            default: begin
                                phase <= SETUP;
                                if (row == IDX_LAST) begin
                                    state <= SHOW;
                                end else begin
                                    row <= row + 1'b1;
                                end
                            end
                        endcase
                    end
                end

                SHOW: begin
                    if (cnt != ON_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (layer == IDX_LAST) begin
                            layer      <= '0;
                            frame_done <= 1'b1;
                            if (pending) begin
                                fsel     <= ~fsel;
                                pending  <= 1'b0;
                                swap_ack <= 1'b1;
                            end
                        end else begin
                            layer <= layer + 1'b1;
                        end
                        state <= enable ? BLANK : IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
